fmul_stream: RTL and testbench
==============================

FMUL_STREAM -- requirements
Module: fmul_stream

Interface
REQ-001 The block SHALL expose parameter LATENCY, default 3, the input-to-output latency in cycles when unstalled (legal 3..6).
REQ-002 The block SHALL expose parameter TAG_W, default 4, the width of a sideband tag carried alongside each operation (legal 1..16).
REQ-003 The block SHALL expose clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL expose rst_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL expose in_valid (input, 1) and in_ready (output, 1) as the input handshake.
REQ-006 The block SHALL expose in_a and in_b, both input, 32, IEEE-754 binary32 operands.
REQ-007 The block SHALL expose in_tag, input, TAG_W, opaque sideband data.
REQ-008 The block SHALL expose out_valid (output, 1) and out_ready (input, 1) as the output handshake.
REQ-009 The block SHALL expose out_result, output, 32, the binary32 product.
REQ-010 The block SHALL expose out_tag, output, TAG_W, equal to the in_tag of the same operation.
REQ-011 The block SHALL expose out_flags, output, 4, ordered {invalid, overflow, underflow, inexact}.

Function
REQ-012 An operation SHALL be accepted on a cycle where in_valid && in_ready.
REQ-013 in_ready SHALL equal !out_valid || out_ready; when in_ready is 0, every pipeline register holds, including bubbles.
REQ-014 With out_ready held at 1, the result SHALL appear with out_valid=1 exactly LATENCY cycles after acceptance, giving a throughput of one operation per cycle.
REQ-015 Results SHALL emerge in acceptance order; the pipeline SHALL neither drop nor duplicate operations.
REQ-016 While out_valid=1 and out_ready=0, out_result, out_tag and out_flags SHALL remain stable.
REQ-017 The pipeline SHALL be split into three core stages, in order:
- unpack, classify, 24x24 mantissa multiply;
- normalise, with guard/round/sticky extraction;
- round and pack.
REQ-018 LATENCY-3 additional stall-aware register stages SHALL follow the core stages.
REQ-019 Input subnormals SHALL be treated as signed zero; no flag SHALL be raised for this.
REQ-020 Rounding SHALL be round-to-nearest-even.
REQ-021 A mantissa carry-out from rounding SHALL increment the exponent.
REQ-022 Exponent arithmetic SHALL use at least 10 signed bits, so that no wrap-around occurs.
REQ-023 Result sign SHALL be sign_a XOR sign_b for all non-NaN results.
REQ-024 Special cases SHALL apply in this priority order:
- either operand NaN -> 0x7FC00000; invalid=1 only if that NaN is signalling (frac[22]=0).
- zero x Inf -> 0x7FC00000 with invalid=1.
- Inf x nonzero -> signed Inf, no flags.
- zero x finite -> signed zero, no flags.
REQ-025 If the rounded exponent is >= 255, the result SHALL be signed Inf with overflow=1 and inexact=1.
REQ-026 If the rounded exponent is <= 0 for a nonzero product, the result SHALL be signed zero (flush-to-zero) with underflow=1 and inexact=1.
REQ-027 Otherwise, inexact SHALL be set iff any of guard, round or sticky is 1.
REQ-028 Flags SHALL be per-operation and SHALL NOT be sticky across operations.

Reset
REQ-029 While rst_n=0, out_valid SHALL be 0 and all internal valid bits SHALL be 0, asynchronously.
REQ-030 While rst_n=0, out_result, out_tag and out_flags SHALL be 0.
REQ-031 While rst_n=0, in_ready SHALL be 1 (since out_valid=0).
REQ-032 Operations in flight when reset asserts SHALL be discarded; no result for them SHALL ever appear.
REQ-033 The first operation accepted after rst_n deasserts SHALL complete with the normal LATENCY.

Verification
REQ-034 Basic product, LATENCY=3, out_ready=1: 0x3FC00000 x 0x40000000, tag 5 -> 3 cycles later 0x40400000, tag 5, flags 0000.
REQ-035 Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002, flags 0001.
REQ-036 Specials:
- 0x00000000 x 0xFF800000 -> 0x7FC00000, flags 1000.
- 0x7F7FFFFF x 0x40000000 -> 0x7F800000, flags 0101.
- 0x00800000 x 0x3F000000 -> 0x00000000, flags 0011.
- 0x80000001 x 0x3F800000 -> 0x80000000, flags 0000.
REQ-037 Backpressure: stream 8 operations with out_ready low for 5 cycles mid-stream -> in_ready low during the stall, output held stable, all 8 results in order with correct tags.
REQ-038 Reset mid-flight: accept 2 operations, assert rst_n for 1 cycle -> out_valid stays 0 with no stale results, and the next operation completes after LATENCY cycles.
REQ-039 Parameter sweep: LATENCY=6, TAG_W=16 -> identical results, delayed by exactly 6 cycles.

Source files
------------

// File: rtl/fmul_stream.sv
// Streaming IEEE-754 binary32 multiplier with valid/ready handshake and sideband tag.
// Three core stages (unpack/multiply, normalise, round/pack) plus LATENCY-3 delay stages.
module fmul_stream #(
   parameter int unsigned LATENCY = 3,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_flags
);

   localparam int unsigned NumExtra = LATENCY - 3;

   logic adv;

   logic [7:0]  exp_a, exp_b;
   logic [22:0] frac_a, frac_b;
   logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan;

   logic                    s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
   logic                    s1_special_q, s1_special_d;
   logic signed [9:0]       s1_exp_q, s1_exp_d;
   logic [47:0]             s1_prod_q, s1_prod_d;
   logic [31:0]             s1_spec_res_q, s1_spec_res_d;
   logic [3:0]              s1_spec_flags_q, s1_spec_flags_d;
   logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;

   logic                    s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
   logic                    s2_special_q, s2_special_d;
   logic signed [9:0]       s2_exp_q, s2_exp_d;
   logic [23:0]             s2_mant_q, s2_mant_d;
   logic                    s2_grd_q, s2_grd_d, s2_rnd_q, s2_rnd_d, s2_stk_q, s2_stk_d;
   logic [31:0]             s2_spec_res_q, s2_spec_res_d;
   logic [3:0]              s2_spec_flags_q, s2_spec_flags_d;
   logic [TAG_W-1:0]        s2_tag_q, s2_tag_d;

   logic                    round_up;
   logic [24:0]             mant_rnd;
   logic signed [9:0]       exp_rnd;
   logic [22:0]             frac_rnd;

   // Index 0 is the round/pack stage; higher indices are pure delay stages.
   logic                    pipe_valid_q [NumExtra+1];
   logic                    pipe_valid_d [NumExtra+1];
   logic [31:0]             pipe_res_q   [NumExtra+1];
   logic [31:0]             pipe_res_d   [NumExtra+1];
   logic [3:0]              pipe_flags_q [NumExtra+1];
   logic [3:0]              pipe_flags_d [NumExtra+1];
   logic [TAG_W-1:0]        pipe_tag_q   [NumExtra+1];
   logic [TAG_W-1:0]        pipe_tag_d   [NumExtra+1];

   assign out_valid  = pipe_valid_q[NumExtra];
   assign out_result = pipe_res_q[NumExtra];
   assign out_flags  = pipe_flags_q[NumExtra];
   assign out_tag    = pipe_tag_q[NumExtra];

   // Whole pipeline moves or holds as one, bubbles included.
   assign in_ready = !out_valid || out_ready;
   assign adv      = in_ready;

   assign exp_a  = in_a[30:23];
   assign exp_b  = in_b[30:23];
   assign frac_a = in_a[22:0];
   assign frac_b = in_b[22:0];
   assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
   assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
   assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
   assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
   // Subnormals count as zero.
   assign zero_a = (exp_a == 8'h00);
   assign zero_b = (exp_b == 8'h00);
   assign snan   = (nan_a && !frac_a[22]) || (nan_b && !frac_b[22]);

   always_comb begin
      s1_valid_d      = in_valid;
      s1_sign_d       = in_a[31] ^ in_b[31];
      s1_exp_d        = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
      s1_prod_d       = {24'd0, 1'b1, frac_a} * {24'd0, 1'b1, frac_b};
      s1_tag_d        = in_tag;
      s1_special_d    = 1'b1;
      s1_spec_res_d   = 32'h7FC0_0000;
      s1_spec_flags_d = 4'b0000;
      if (nan_a || nan_b) begin
         s1_spec_flags_d = {snan, 3'b000};
      end else if ((zero_a && inf_b) || (inf_a && zero_b)) begin
         s1_spec_flags_d = 4'b1000;
      end else if (inf_a || inf_b) begin
         s1_spec_res_d = {s1_sign_d, 8'hFF, 23'd0};
      end else if (zero_a || zero_b) begin
         s1_spec_res_d = {s1_sign_d, 31'd0};
      end else begin
         s1_special_d  = 1'b0;
         s1_spec_res_d = 32'd0;
      end
   end

   always_comb begin
      s2_valid_d      = s1_valid_q;
      s2_sign_d       = s1_sign_q;
      s2_special_d    = s1_special_q;
      s2_spec_res_d   = s1_spec_res_q;
      s2_spec_flags_d = s1_spec_flags_q;
      s2_tag_d        = s1_tag_q;
      if (s1_prod_q[47]) begin
         s2_exp_d  = s1_exp_q + 10'sd1;
         s2_mant_d = s1_prod_q[47:24];
         s2_grd_d  = s1_prod_q[23];
         s2_rnd_d  = s1_prod_q[22];
         s2_stk_d  = |s1_prod_q[21:0];
      end else begin
         s2_exp_d  = s1_exp_q;
         s2_mant_d = s1_prod_q[46:23];
         s2_grd_d  = s1_prod_q[22];
         s2_rnd_d  = s1_prod_q[21];
         s2_stk_d  = |s1_prod_q[20:0];
      end
   end

   always_comb begin
      round_up = s2_grd_q && (s2_rnd_q || s2_stk_q || s2_mant_q[0]);
      mant_rnd = {1'b0, s2_mant_q} + {24'd0, round_up};
      exp_rnd  = s2_exp_q + (mant_rnd[24] ? 10'sd1 : 10'sd0);
      frac_rnd = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];

      pipe_valid_d[0] = s2_valid_q;
      pipe_tag_d[0]   = s2_tag_q;
      if (s2_special_q) begin
         pipe_res_d[0]   = s2_spec_res_q;
         pipe_flags_d[0] = s2_spec_flags_q;
      end else if (exp_rnd >= 10'sd255) begin
         pipe_res_d[0]   = {s2_sign_q, 8'hFF, 23'd0};
         pipe_flags_d[0] = 4'b0101;
      end else if (exp_rnd <= 10'sd0) begin
         pipe_res_d[0]   = {s2_sign_q, 31'd0};
         pipe_flags_d[0] = 4'b0011;
      end else begin
         pipe_res_d[0]   = {s2_sign_q, exp_rnd[7:0], frac_rnd};
         pipe_flags_d[0] = {3'b000, s2_grd_q | s2_rnd_q | s2_stk_q};
      end

      for (int i = 1; i <= int'(NumExtra); i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
         pipe_res_d[i]   = pipe_res_q[i-1];
         pipe_flags_d[i] = pipe_flags_q[i-1];
         pipe_tag_d[i]   = pipe_tag_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q      <= 1'b0;
         s1_sign_q       <= 1'b0;
         s1_special_q    <= 1'b0;
         s1_exp_q        <= '0;
         s1_prod_q       <= '0;
         s1_spec_res_q   <= '0;
         s1_spec_flags_q <= '0;
         s1_tag_q        <= '0;
         s2_valid_q      <= 1'b0;
         s2_sign_q       <= 1'b0;
         s2_special_q    <= 1'b0;
         s2_exp_q        <= '0;
         s2_mant_q       <= '0;
         s2_grd_q        <= 1'b0;
         s2_rnd_q        <= 1'b0;
         s2_stk_q        <= 1'b0;
         s2_spec_res_q   <= '0;
         s2_spec_flags_q <= '0;
         s2_tag_q        <= '0;
         for (int i = 0; i <= int'(NumExtra); i++) begin
            pipe_valid_q[i] <= 1'b0;
            pipe_res_q[i]   <= '0;
            pipe_flags_q[i] <= '0;
            pipe_tag_q[i]   <= '0;
         end
      end else if (adv) begin
         s1_valid_q      <= s1_valid_d;
         s1_sign_q       <= s1_sign_d;
         s1_special_q    <= s1_special_d;
         s1_exp_q        <= s1_exp_d;
         s1_prod_q       <= s1_prod_d;
         s1_spec_res_q   <= s1_spec_res_d;
         s1_spec_flags_q <= s1_spec_flags_d;
         s1_tag_q        <= s1_tag_d;
         s2_valid_q      <= s2_valid_d;
         s2_sign_q       <= s2_sign_d;
         s2_special_q    <= s2_special_d;
         s2_exp_q        <= s2_exp_d;
         s2_mant_q       <= s2_mant_d;
         s2_grd_q        <= s2_grd_d;
         s2_rnd_q        <= s2_rnd_d;
         s2_stk_q        <= s2_stk_d;
         s2_spec_res_q   <= s2_spec_res_d;
         s2_spec_flags_q <= s2_spec_flags_d;
         s2_tag_q        <= s2_tag_d;
         for (int i = 0; i <= int'(NumExtra); i++) begin
            pipe_valid_q[i] <= pipe_valid_d[i];
            pipe_res_q[i]   <= pipe_res_d[i];
            pipe_flags_q[i] <= pipe_flags_d[i];
            pipe_tag_q[i]   <= pipe_tag_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fmul_stream.sv
// Scoreboard bench for fmul_stream: one LATENCY=3/TAG_W=4 instance and one LATENCY=6/TAG_W=16
// instance, each checked against a behavioural binary32 multiply model.
module tb_fmul_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_a, in_b;
   logic [15:0] in_tag;
   logic        v3, v6, rdy3, rdy6, ordy3, ordy6, ovalid3, ovalid6;
   logic [31:0] res3, res6;
   logic [3:0]  tag3, fl3, fl6;
   logic [15:0] tag6;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit lat_chk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flags;
      logic [15:0] tag;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t q3[$];
   exp_t q6[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fmul_stream #(.LATENCY(3), .TAG_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_a(in_a), .in_b(in_b),
      .in_tag(in_tag[3:0]), .out_valid(ovalid3), .out_ready(ordy3), .out_result(res3),
      .out_tag(tag3), .out_flags(fl3)
   );

   fmul_stream #(.LATENCY(6), .TAG_W(16)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6), .in_a(in_a), .in_b(in_b),
      .in_tag(in_tag), .out_valid(ovalid6), .out_ready(ordy6), .out_result(res6),
      .out_tag(tag6), .out_flags(fl6)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Returns {flags, result}.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [7:0]  ea, eb;
      logic [22:0] fa, fb;
      logic        s, na, nb, ia, ib, za, zb, inx, inv;
      logic [63:0] p, keep, rem, half;
      int          e, sh;
      ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
      s  = a[31] ^ b[31];
      na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
      ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
      za = (ea == 0); zb = (eb == 0);
      if (na || nb) begin
         inv = (na && !fa[22]) || (nb && !fb[22]);
         return {inv, 3'b000, 32'h7FC0_0000};
      end
      if ((za && ib) || (ia && zb)) return {4'b1000, 32'h7FC0_0000};
      if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
      if (za || zb) return {4'b0000, s, 31'd0};
      p  = {40'd0, 1'b1, fa} * {40'd0, 1'b1, fb};
      e  = int'(ea) + int'(eb) - 127;
      sh = p[47] ? 24 : 23;
      if (p[47]) e++;
      keep = p >> sh;
      rem  = p - (keep << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'd1 << 24)) begin
         keep = keep >> 1;
         e++;
      end
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0) return {4'b0011, s, 31'd0};
      return {3'b000, inx, s, 8'(e), keep[22:0]};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (ovalid3) begin
            if (q3.size() == 0) begin
               check("spurious3", {63'd0, ovalid3}, 64'd0);
            end else begin
               check("res3", {32'd0, res3}, {32'd0, q3[0].res});
               check("flags3", {60'd0, fl3}, {60'd0, q3[0].flags});
               check("tag3", {60'd0, tag3}, {48'd0, q3[0].tag});
               if (ordy3) begin
                  if (q3[0].lat && lat_chk) check("lat3", 64'(cyc + 1 - q3[0].acc), 64'd3);
                  void'(q3.pop_front());
               end
            end
         end
         if (v3 && rdy3) begin
            exp_t e;
            logic [35:0] m;
            m = model(in_a, in_b);
            e.res = m[31:0]; e.flags = m[35:32]; e.tag = {12'd0, in_tag[3:0]};
            e.acc = cyc + 1; e.lat = lat_chk;
            q3.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ovalid6) begin
            if (q6.size() == 0) begin
               check("spurious6", {63'd0, ovalid6}, 64'd0);
            end else begin
               check("res6", {32'd0, res6}, {32'd0, q6[0].res});
               check("flags6", {60'd0, fl6}, {60'd0, q6[0].flags});
               check("tag6", {48'd0, tag6}, {48'd0, q6[0].tag});
               if (ordy6) begin
                  if (q6[0].lat && lat_chk) check("lat6", 64'(cyc + 1 - q6[0].acc), 64'd6);
                  void'(q6.pop_front());
               end
            end
         end
         if (v6 && rdy6) begin
            exp_t e;
            logic [35:0] m;
            m = model(in_a, in_b);
            e.res = m[31:0]; e.flags = m[35:32]; e.tag = in_tag;
            e.acc = cyc + 1; e.lat = lat_chk;
            q6.push_back(e);
         end
      end
   end

   task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] t);
      int  n;
      logic r;
      in_a = a; in_b = b; in_tag = t;
      if (sel == 0) v3 = 1'b1; else v6 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         r = (sel == 0) ? rdy3 : rdy6;
      end while (!r && n < 100);
      if (!r) check("accept_timeout", {63'd0, r}, 64'd1);
      @(posedge clk);
      #1;
      v3 = 1'b0; v6 = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q3.size() != 0 || q6.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain", 64'(q3.size() + q6.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_op(input bit wide);
      logic [31:0] r;
      r = $urandom;
      if (!wide) r[30:23] = 8'($urandom_range(90, 165));
      return r;
   endfunction

   logic [31:0] va [14];
   logic [31:0] vb [14];

   initial begin
      va[0]  = 32'h3FC0_0000; vb[0]  = 32'h4000_0000;
      va[1]  = 32'h3F80_0001; vb[1]  = 32'h3F80_0001;
      va[2]  = 32'h0000_0000; vb[2]  = 32'hFF80_0000;
      va[3]  = 32'h7F7F_FFFF; vb[3]  = 32'h4000_0000;
      va[4]  = 32'h0080_0000; vb[4]  = 32'h3F00_0000;
      va[5]  = 32'h8000_0001; vb[5]  = 32'h3F80_0000;
      va[6]  = 32'h7FA0_0000; vb[6]  = 32'h3F80_0000;
      va[7]  = 32'h7FC0_0001; vb[7]  = 32'h0000_0000;
      va[8]  = 32'hFF80_0000; vb[8]  = 32'hC000_0000;
      va[9]  = 32'h3F80_0000; vb[9]  = 32'h3F80_0000;
      va[10] = 32'h3F80_0001; vb[10] = 32'h3FC0_0000;
      va[11] = 32'h3F80_0003; vb[11] = 32'h3FC0_0000;
      va[12] = 32'h3FFF_FFFE; vb[12] = 32'h3F80_0001;
      va[13] = 32'h8000_0000; vb[13] = 32'h7F80_0000;

      v3 = 0; v6 = 0; ordy3 = 1; ordy6 = 1; lat_chk = 1;
      in_a = 0; in_b = 0; in_tag = 0;
      rst_n = 0;
      #1;
      check("rst_valid3", {63'd0, ovalid3}, 64'd0);
      check("rst_ready3", {63'd0, rdy3}, 64'd1);
      check("rst_res3", {32'd0, res3}, 64'd0);
      check("rst_tag3", {60'd0, tag3}, 64'd0);
      check("rst_flags3", {60'd0, fl3}, 64'd0);
      check("rst_valid6", {63'd0, ovalid6}, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk);
      #1;

      // Directed vectors, back to back
      for (int i = 0; i < 14; i++) send(0, va[i], vb[i], 16'(i + 5));
      drain();

      for (int i = 0; i < 24; i++) send(0, rnd_op(i % 5 == 0), rnd_op(i % 7 == 0), 16'(i));
      drain();

      // Backpressure: 5-cycle output stall mid-stream
      lat_chk = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(0, rnd_op(1'b0), rnd_op(1'b0), 16'(i + 3));
         end
         begin
            repeat (4) @(posedge clk);
            #1 ordy3 = 0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("stall_in_ready", {63'd0, rdy3}, 64'd0);
               check("stall_out_valid", {63'd0, ovalid3}, 64'd1);
            end
            @(posedge clk);
            #1 ordy3 = 1;
         end
      join
      drain();
      lat_chk = 1;

      // Reset with two operations in flight
      send(0, 32'h4040_0000, 32'h4080_0000, 16'd9);
      send(0, 32'h3F80_0001, 32'h3F80_0001, 16'd10);
      rst_n = 0;
      q3.delete();
      #1;
      check("midrst_valid", {63'd0, ovalid3}, 64'd0);
      check("midrst_ready", {63'd0, rdy3}, 64'd1);
      check("midrst_res", {32'd0, res3}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("no_stale", {63'd0, ovalid3}, 64'd0);
      end
      @(posedge clk);
      #1;
      send(0, 32'h3FC0_0000, 32'h4000_0000, 16'd5);
      drain();

      // Deeper, wider instance
      for (int i = 0; i < 14; i++) send(1, va[i], vb[i], 16'hA000 + 16'(i * 257));
      for (int i = 0; i < 10; i++) send(1, rnd_op(1'b0), rnd_op(i % 3 == 0), 16'($urandom));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
